frame_swap_ctrl: RTL and testbench

- Parametrised N-buffer (2..4) frame-buffer ownership controller.
- Sits between the vga scanout (port A, read) and the object renderer (port B, write) in front of a single flat frame memory.
- Tracks which buffer is displayed, rendered and ready, and swaps on VGA frame boundaries. Supports triple buffering with optional stale-frame dropping.
- Converts x/y addresses to registered flat memory addresses and reports frame drop/repeat statistics.

---
 rtl/frame_swap_ctrl_pkg.sv | 21 ++
 rtl/frame_swap_ctrl_addr_gen.sv | 47 ++++
 rtl/frame_swap_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_frame_swap_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_swap_ctrl_pkg.sv
// Shared types for the frame-buffer ownership controller.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package frame_swap_ctrl_pkg;

    // RGB444 pixel as written by the object renderer.
    typedef logic [11:0] pixel_t;

    typedef enum logic [1:0] {
        FREE,
        RENDERING,
        READY,
        DISPLAYING
    } buf_state_e;

    // Index width for n buffers, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_swap_ctrl_addr_gen.sv
// Registered x/y to flat frame-memory address converter with range check.
// Latency: one cycle from coordinate/idx/en to addr/oob/we.
// Backpressure: none; out-of-range coordinates zero the address and drop the write.
module fb_addr_gen
    import frame_swap_ctrl_pkg::*;
#(
    parameter int FB_W   = 640,
    parameter int FB_H   = 480,
    parameter int IDX_W  = 1,
    parameter int ADDR_W = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  idx,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              oob,
    output logic              we
);

    logic              in_range;
    logic [ADDR_W-1:0] flat;

    // Range check and flat address, all arithmetic at full address width.
    always_comb begin
        in_range = (int'(x) < FB_W) && (int'(y) < FB_H);
        flat     = ADDR_W'(idx) * ADDR_W'(FB_W * FB_H)
                 + ADDR_W'(y) * ADDR_W'(FB_W)
                 + ADDR_W'(x);
    end

    // Output register; an out-of-range coordinate never reaches memory.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr <= '0;
            oob  <= 1'b0;
            we   <= 1'b0;
        end else begin
            addr <= in_range ? flat : '0;
            oob  <= ~in_range;
            we   <= en & in_range;
        end
    end

endmodule

// File: rtl/frame_swap_ctrl.sv
// Frame-buffer ownership controller: tracks display/render/ready buffers, swaps on VGA frame end.
// Latency: ownership, statistics and both memory address ports update one clock after their inputs.
// Backpressure: render_grant=0 holds the renderer off while no buffer can be handed to it.
module frame_swap_ctrl
    import frame_swap_ctrl_pkg::*;
#(
    parameter int NUM_BUFFERS = 2,
    parameter int FB_W        = 640,
    parameter int FB_H        = 480,
    parameter int DROP_STALE  = 0,
    parameter int CNT_W       = 16,
    localparam int ADDR_W     = $clog2(NUM_BUFFERS * FB_W * FB_H),
    localparam int IDX_W      = clog2_min1(NUM_BUFFERS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vga_frame_complete,
    input  logic              render_done,
    input  logic [9:0]        address_a_x,
    input  logic [9:0]        address_a_y,
    input  logic [9:0]        address_b_x,
    input  logic [9:0]        address_b_y,
    input  pixel_t            write_data_b,
    input  logic              write_enable_b,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic [ADDR_W-1:0] mem_addr_b,
    output pixel_t            mem_wdata_b,
    output logic              mem_we_b,
    output logic              oob_a,
    output logic              render_grant,
    output logic              next_frame,
    output logic [IDX_W-1:0]  display_idx,
    output logic [IDX_W-1:0]  render_idx,
    output logic [CNT_W-1:0]  dropped_frames,
    output logic [CNT_W-1:0]  repeated_frames
);

    buf_state_e       buf_st   [NUM_BUFFERS];
    buf_state_e       buf_st_n [NUM_BUFFERS];
    logic [IDX_W-1:0] display_idx_n, render_idx_n, ready_idx, free_idx;
    logic             grant_n, pend, pend_n;
    logic             has_ready, ready_after, has_free;
    logic             swap, rep_inc, drop_inc;
    logic             unused_we_a, unused_oob_b;

    // Ownership next state: swap first, then the finished frame, then allocation.
    // pend marks a finished render buffer waiting for the READY slot to empty
    // (stall mode only); the renderer holds it but may not write.
    always_comb begin
        buf_st_n      = buf_st;
        display_idx_n = display_idx;
        render_idx_n  = render_idx;
        grant_n       = render_grant;
        pend_n        = pend;
        swap          = 1'b0;
        rep_inc       = 1'b0;
        drop_inc      = 1'b0;
        has_ready     = 1'b0;
        ready_idx     = '0;
        ready_after   = 1'b0;
        has_free      = 1'b0;
        free_idx      = '0;

        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (buf_st[i] == READY) begin
                has_ready = 1'b1;
                ready_idx = IDX_W'(i);
            end
        end

        if (vga_frame_complete) begin
            if (has_ready) begin
                swap                  = 1'b1;
                buf_st_n[display_idx] = FREE;
                buf_st_n[ready_idx]   = DISPLAYING;
                display_idx_n         = ready_idx;
            end else begin
                rep_inc = 1'b1;
            end
        end

        if (render_done && render_grant) begin
            grant_n = 1'b0;
            if (!has_ready || swap) begin
                buf_st_n[render_idx] = READY;
            end else if (DROP_STALE != 0) begin
                buf_st_n[ready_idx]  = FREE;
                buf_st_n[render_idx] = READY;
                drop_inc             = 1'b1;
            end else begin
                pend_n = 1'b1;
            end
        end else if (pend && swap) begin
            buf_st_n[render_idx] = READY;
            pend_n               = 1'b0;
        end

        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (buf_st_n[i] == READY) ready_after = 1'b1;
        end
        for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
            if (buf_st_n[i] == FREE) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end

        if (!grant_n && !pend_n && has_free &&
            (DROP_STALE != 0 || !ready_after || NUM_BUFFERS >= 3)) begin
            buf_st_n[free_idx] = RENDERING;
            render_idx_n       = free_idx;
            grant_n            = 1'b1;
        end
    end

    // Ownership state register; reset hands buffer 0 to scanout and buffer 1 to the renderer.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                buf_st[i] <= (i == 0) ? DISPLAYING : ((i == 1) ? RENDERING : FREE);
            end
            display_idx  <= '0;
            render_idx   <= IDX_W'(1);
            render_grant <= 1'b1;
            pend         <= 1'b0;
            next_frame   <= 1'b0;
        end else begin
            buf_st       <= buf_st_n;
            display_idx  <= display_idx_n;
            render_idx   <= render_idx_n;
            render_grant <= grant_n;
            pend         <= pend_n;
            next_frame   <= swap;
        end
    end

    // Saturating drop/repeat statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            dropped_frames  <= '0;
            repeated_frames <= '0;
        end else begin
            if (drop_inc && dropped_frames != '1) dropped_frames <= dropped_frames + CNT_W'(1);
            if (rep_inc && repeated_frames != '1) repeated_frames <= repeated_frames + CNT_W'(1);
        end
    end

    // Write data follows the write address pipeline stage.
    always_ff @(posedge clock) begin
        if (reset) mem_wdata_b <= '0;
        else       mem_wdata_b <= write_data_b;
    end

    fb_addr_gen #(
        .FB_W   (FB_W),
        .FB_H   (FB_H),
        .IDX_W  (IDX_W),
        .ADDR_W (ADDR_W)
    ) u_addr_a (
        .clock (clock),
        .reset (reset),
        .idx   (display_idx),
        .x     (address_a_x),
        .y     (address_a_y),
        .en    (1'b0),
        .addr  (mem_addr_a),
        .oob   (oob_a),
        .we    (unused_we_a)
    );

    fb_addr_gen #(
        .FB_W   (FB_W),
        .FB_H   (FB_H),
        .IDX_W  (IDX_W),
        .ADDR_W (ADDR_W)
    ) u_addr_b (
        .clock (clock),
        .reset (reset),
        .idx   (render_idx),
        .x     (address_b_x),
        .y     (address_b_y),
        .en    (write_enable_b & render_grant),
        .addr  (mem_addr_b),
        .oob   (unused_oob_b),
        .we    (mem_we_b)
    );

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Bench for frame_swap_ctrl: three configurations driven with shared stimulus.
// Latency: outputs checked 1 time unit after each rising edge against a buffer-set model.
// Backpressure: renderer grant tracked by the model.
module tb_frame_swap_ctrl;
    import frame_swap_ctrl_pkg::*;

    localparam int FB_W    = 640;
    localparam int FB_H    = 480;
    localparam int CNT_MAX = 65535;

    logic       clock;
    logic       reset;
    logic       vga_frame_complete, render_done, write_enable_b;
    logic [9:0] address_a_x, address_a_y, address_b_x, address_b_y;
    pixel_t     write_data_b;

    logic [19:0] mem_addr_a [3];
    logic [19:0] mem_addr_b [3];
    pixel_t      mem_wdata_b [3];
    logic        mem_we_b [3], oob_a [3], render_grant [3], next_frame [3];
    logic [15:0] dropped_frames [3], repeated_frames [3];
    logic [0:0]  di_0, ri_0;
    logic [1:0]  di_1, ri_1, di_2, ri_2;
    logic [31:0] dix [3], rix [3];

    assign dix[0] = 32'(di_0);
    assign dix[1] = 32'(di_1);
    assign dix[2] = 32'(di_2);
    assign rix[0] = 32'(ri_0);
    assign rix[1] = 32'(ri_1);
    assign rix[2] = 32'(ri_2);

    // k=0: 2 buffers stall; k=1: 3 buffers drop stale; k=2: 3 buffers stall.
    frame_swap_ctrl #(.NUM_BUFFERS(2), .DROP_STALE(0)) u_dut2 (
        .clock(clock), .reset(reset), .vga_frame_complete(vga_frame_complete), .render_done(render_done),
        .address_a_x(address_a_x), .address_a_y(address_a_y), .address_b_x(address_b_x), .address_b_y(address_b_y),
        .write_data_b(write_data_b), .write_enable_b(write_enable_b),
        .mem_addr_a(mem_addr_a[0]), .mem_addr_b(mem_addr_b[0]), .mem_wdata_b(mem_wdata_b[0]), .mem_we_b(mem_we_b[0]),
        .oob_a(oob_a[0]), .render_grant(render_grant[0]), .next_frame(next_frame[0]),
        .display_idx(di_0), .render_idx(ri_0), .dropped_frames(dropped_frames[0]), .repeated_frames(repeated_frames[0]));

    frame_swap_ctrl #(.NUM_BUFFERS(3), .DROP_STALE(1)) u_dut3d (
        .clock(clock), .reset(reset), .vga_frame_complete(vga_frame_complete), .render_done(render_done),
        .address_a_x(address_a_x), .address_a_y(address_a_y), .address_b_x(address_b_x), .address_b_y(address_b_y),
        .write_data_b(write_data_b), .write_enable_b(write_enable_b),
        .mem_addr_a(mem_addr_a[1]), .mem_addr_b(mem_addr_b[1]), .mem_wdata_b(mem_wdata_b[1]), .mem_we_b(mem_we_b[1]),
        .oob_a(oob_a[1]), .render_grant(render_grant[1]), .next_frame(next_frame[1]),
        .display_idx(di_1), .render_idx(ri_1), .dropped_frames(dropped_frames[1]), .repeated_frames(repeated_frames[1]));

    frame_swap_ctrl #(.NUM_BUFFERS(3), .DROP_STALE(0)) u_dut3s (
        .clock(clock), .reset(reset), .vga_frame_complete(vga_frame_complete), .render_done(render_done),
        .address_a_x(address_a_x), .address_a_y(address_a_y), .address_b_x(address_b_x), .address_b_y(address_b_y),
        .write_data_b(write_data_b), .write_enable_b(write_enable_b),
        .mem_addr_a(mem_addr_a[2]), .mem_addr_b(mem_addr_b[2]), .mem_wdata_b(mem_wdata_b[2]), .mem_we_b(mem_we_b[2]),
        .oob_a(oob_a[2]), .render_grant(render_grant[2]), .next_frame(next_frame[2]),
        .display_idx(di_2), .render_idx(ri_2), .dropped_frames(dropped_frames[2]), .repeated_frames(repeated_frames[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: displayed buffer, the single ready slot (-1 = empty), the renderer's
    // buffer with grant/pending flags; free buffers are whatever is left over.
    typedef struct {
        int          n;
        bit          ds;
        int          disp, ready, rend;
        bit          grant, pend, nf;
        int          drop, rep;
        logic [31:0] e_aa, e_ab, e_wd;
        bit          e_oob, e_we, e_bchk;
    } mdl_t;
    mdl_t m [3];

    typedef struct {
        logic [9:0] ax, ay, bx, by;
        bit         we;
        int         exp_aa;
        bit         exp_oob;
        int         exp_ab;   // -1: address not checked
        bit         exp_we;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic model_reset(input int k);
        m[k].disp = 0;  m[k].ready = -1; m[k].rend = 1;
        m[k].grant = 1; m[k].pend = 0;   m[k].nf = 0;
        m[k].drop = 0;  m[k].rep = 0;
        m[k].e_aa = 0;  m[k].e_ab = 0;   m[k].e_wd = 0;
        m[k].e_oob = 0; m[k].e_we = 0;   m[k].e_bchk = 1;
    endtask

    task automatic model_step(input int k, input bit rst, input bit vfc, input bit done,
                              input int ax, input int ay, input int bx, input int by,
                              input bit we, input int wd);
        bit a_ok, b_ok, fin, swapped;
        int fb;
        if (rst) begin
            model_reset(k);
        end else begin
            a_ok = (ax < FB_W) && (ay < FB_H);
            b_ok = (bx < FB_W) && (by < FB_H);
            m[k].e_aa   = a_ok ? (m[k].disp * FB_W * FB_H + ay * FB_W + ax) : 0;
            m[k].e_oob  = !a_ok;
            m[k].e_we   = we && m[k].grant && b_ok;
            m[k].e_bchk = b_ok;
            m[k].e_ab   = m[k].rend * FB_W * FB_H + by * FB_W + bx;
            m[k].e_wd   = wd;
            fin     = done && m[k].grant;
            swapped = vfc && (m[k].ready >= 0);
            m[k].nf = swapped;
            if (swapped) begin
                m[k].disp  = m[k].ready;
                m[k].ready = -1;
            end else if (vfc && m[k].rep < CNT_MAX) begin
                m[k].rep++;
            end
            if (fin) begin
                m[k].grant = 0;
                if (m[k].ready < 0) m[k].ready = m[k].rend;
                else if (m[k].ds) begin
                    m[k].ready = m[k].rend;
                    if (m[k].drop < CNT_MAX) m[k].drop++;
                end else m[k].pend = 1;
            end else if (m[k].pend && swapped) begin
                m[k].ready = m[k].rend;
                m[k].pend  = 0;
            end
            if (!m[k].grant && !m[k].pend && (m[k].ds || m[k].ready < 0 || m[k].n >= 3)) begin
                fb = -1;
                for (int b = m[k].n - 1; b >= 0; b--)
                    if (b != m[k].disp && b != m[k].ready) fb = b;
                if (fb >= 0) begin
                    m[k].rend  = fb;
                    m[k].grant = 1;
                end
            end
        end
    endtask

    task automatic cmp_model(input int k);
        string p;
        p = $sformatf("model_u%0d", k);
        chk({p, ".display_idx"}, dix[k], m[k].disp);
        chk({p, ".render_grant"}, 32'(render_grant[k]), 32'(m[k].grant));
        if (m[k].grant) chk({p, ".render_idx"}, rix[k], m[k].rend);
        chk({p, ".next_frame"}, 32'(next_frame[k]), 32'(m[k].nf));
        chk({p, ".dropped"}, 32'(dropped_frames[k]), m[k].drop);
        chk({p, ".repeated"}, 32'(repeated_frames[k]), m[k].rep);
        chk({p, ".mem_addr_a"}, 32'(mem_addr_a[k]), m[k].e_aa);
        chk({p, ".oob_a"}, 32'(oob_a[k]), 32'(m[k].e_oob));
        chk({p, ".mem_we_b"}, 32'(mem_we_b[k]), 32'(m[k].e_we));
        chk({p, ".mem_wdata_b"}, 32'(mem_wdata_b[k]), m[k].e_wd);
        if (m[k].e_bchk) chk({p, ".mem_addr_b"}, 32'(mem_addr_b[k]), m[k].e_ab);
    endtask

    // One clock: drive inputs, advance the models, sample after the edge.
    task automatic step(input bit rst, input bit vfc, input bit done,
                        input logic [9:0] ax, input logic [9:0] ay, input logic [9:0] bx, input logic [9:0] by,
                        input bit we, input pixel_t wd);
        reset = rst; vga_frame_complete = vfc; render_done = done;
        address_a_x = ax; address_a_y = ay; address_b_x = bx; address_b_y = by;
        write_enable_b = we; write_data_b = wd;
        for (int k = 0; k < 3; k++)
            model_step(k, rst, vfc, done, int'(ax), int'(ay), int'(bx), int'(by), we, int'(wd));
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) cmp_model(k);
    endtask

    task automatic idle(input bit vfc, input bit done);
        step(1'b0, vfc, done, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 12'h000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        m[0].n = 2; m[0].ds = 0;
        m[1].n = 3; m[1].ds = 1;
        m[2].n = 3; m[2].ds = 0;
        reset = 1'b1; vga_frame_complete = 1'b0; render_done = 1'b0; write_enable_b = 1'b0;
        address_a_x = '0; address_a_y = '0; address_b_x = '0; address_b_y = '0; write_data_b = '0;

        vecs[0] = '{10'd0,    10'd0,    10'd0,   10'd0,   1'b1, 0,      1'b0, 307200, 1'b1};
        vecs[1] = '{10'd639,  10'd479,  10'd639, 10'd479, 1'b1, 307199, 1'b0, 614399, 1'b1};
        vecs[2] = '{10'd5,    10'd2,    10'd640, 10'd0,   1'b1, 1285,   1'b0, -1,     1'b0};
        vecs[3] = '{10'd640,  10'd0,    10'd10,  10'd10,  1'b0, 0,      1'b1, 313610, 1'b0};
        vecs[4] = '{10'd0,    10'd480,  10'd0,   10'd480, 1'b1, 0,      1'b1, -1,     1'b0};
        vecs[5] = '{10'd1023, 10'd1023, 10'd1,   10'd1,   1'b1, 0,      1'b1, 307841, 1'b1};

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 12'h000);
        step(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 12'h000);
        chk("rst.display_idx", dix[0], 0);
        chk("rst.render_idx", rix[0], 1);
        chk("rst.render_grant", 32'(render_grant[0]), 1);
        chk("rst.next_frame", 32'(next_frame[0]), 0);
        chk("rst.mem_we_b", 32'(mem_we_b[0]), 0);
        chk("rst.mem_addr_a", 32'(mem_addr_a[0]), 0);
        chk("rst.mem_addr_b", 32'(mem_addr_b[0]), 0);
        chk("rst.oob_a", 32'(oob_a[0]), 0);
        chk("rst.counters", 32'({dropped_frames[0], repeated_frames[0]}), 0);

        // Address vectors: display buffer 0, render buffer 1.
        for (int v = 0; v < 6; v++) begin
            step(1'b0, 1'b0, 1'b0, vecs[v].ax, vecs[v].ay, vecs[v].bx, vecs[v].by, vecs[v].we, pixel_t'(v + 1));
            chk($sformatf("vec%0d.mem_addr_a", v), 32'(mem_addr_a[0]), vecs[v].exp_aa);
            chk($sformatf("vec%0d.oob_a", v), 32'(oob_a[0]), 32'(vecs[v].exp_oob));
            chk($sformatf("vec%0d.mem_we_b", v), 32'(mem_we_b[0]), 32'(vecs[v].exp_we));
            if (vecs[v].exp_ab >= 0) chk($sformatf("vec%0d.mem_addr_b", v), 32'(mem_addr_b[0]), vecs[v].exp_ab);
        end

        // Two buffers: done at cycle 10, frame end at cycle 50.
        for (int c = 0; c < 60; c++) begin
            idle(c == 50, c == 10);
            if (c + 1 >= 11 && c + 1 <= 50) chk($sformatf("two_buf.grant_c%0d", c + 1), 32'(render_grant[0]), 0);
            chk($sformatf("two_buf.next_frame_c%0d", c + 1), 32'(next_frame[0]), 32'(c == 50));
            if (c + 1 == 51) begin
                chk("two_buf.display_idx_c51", dix[0], 1);
                chk("two_buf.render_idx_c51", rix[0], 0);
                chk("two_buf.grant_c51", 32'(render_grant[0]), 1);
            end
        end

        // Three frame ends with nothing ready.
        for (int c = 0; c < 12; c++) begin
            idle(c % 4 == 1, 1'b0);
            chk("repeat.next_frame", 32'(next_frame[0]), 0);
        end
        chk("repeat.repeated_frames", 32'(repeated_frames[0]), 3);
        chk("repeat.display_idx", dix[0], 1);

        // Mid-run reset, then two finished frames before any frame end.
        step(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 12'h000);
        for (int c = 0; c < 10; c++) idle(1'b0, c == 2 || c == 5);
        chk("drop.dropped_frames", 32'(dropped_frames[1]), 1);
        chk("drop.render_grant", 32'(render_grant[1]), 1);
        chk("stall.render_grant", 32'(render_grant[2]), 0);
        chk("stall.dropped_frames", 32'(dropped_frames[2]), 0);
        idle(1'b1, 1'b0);
        chk("drop.display_idx", dix[1], 2);
        chk("stall.display_idx", dix[2], 1);
        chk("stall.grant_after_swap", 32'(render_grant[2]), 1);
        chk("stall.render_idx_after_swap", rix[2], 0);

        // Simultaneous frame end and done with buffer 2 ready on the stall instance.
        idle(1'b1, 1'b1);
        chk("simul.display_idx", dix[2], 2);
        chk("simul.next_frame", 32'(next_frame[2]), 1);
        chk("simul.render_grant", 32'(render_grant[2]), 1);
        chk("simul.render_idx", rix[2], 1);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        chk("simul.next_display_idx", dix[2], 0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 10'($urandom_range(0, 700)), 10'($urandom_range(0, 520)),
                 10'($urandom_range(0, 700)), 10'($urandom_range(0, 520)),
                 1'($urandom_range(0, 1)), pixel_t'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
